// File: rtl/gmsk_mem_pkg.sv
// Shared types for the unified instruction/data memory arbiter.
package gmsk_mem_pkg;

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_INSTR = 2'd1,
    OWN_DATA  = 2'd2
  } owner_e;

  typedef enum logic {
    DATA_FIRST  = 1'b0,
    INSTR_FIRST = 1'b1
  } rr_e;

  typedef struct packed {
    owner_e owner;
    logic   err;
  } resp_tag_t;

  localparam logic [3:0] BE_FULL = 4'hF;

  function automatic rr_e rr_other(input rr_e ptr);
    return (ptr == DATA_FIRST) ? INSTR_FIRST : DATA_FIRST;
  endfunction

endpackage

// File: rtl/gmsk_mem_arbiter_if.sv
// Core instruction/data ports, SRAM port and bring-up counters of the memory arbiter.
interface gmsk_mem_arbiter_if #(
  parameter int MEM_WORDS = 4096,
  parameter int CNT_W     = 16
);
  localparam int AW = $clog2(MEM_WORDS);

  logic             i_req;
  logic [31:0]      i_addr;
  logic             i_gnt;
  logic             i_rvalid;
  logic [31:0]      i_rdata;
  logic             i_err;

  logic             d_req;
  logic             d_we;
  logic [3:0]       d_be;
  logic [31:0]      d_addr;
  logic [31:0]      d_wdata;
  logic             d_gnt;
  logic             d_rvalid;
  logic [31:0]      d_rdata;
  logic             d_err;

  logic             mem_en;
  logic             mem_we;
  logic [3:0]       mem_be;
  logic [AW-1:0]    mem_addr;
  logic [31:0]      mem_wdata;
  logic             mem_ready;
  logic [31:0]      mem_rdata;

  logic [CNT_W-1:0] i_stall_cnt;
  logic [CNT_W-1:0] d_stall_cnt;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata, mem_ready, mem_rdata,
    output i_gnt, i_rvalid, i_rdata, i_err, d_gnt, d_rvalid, d_rdata, d_err,
           mem_en, mem_we, mem_be, mem_addr, mem_wdata, i_stall_cnt, d_stall_cnt
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata, mem_ready, mem_rdata,
    input  i_gnt, i_rvalid, i_rdata, i_err, d_gnt, d_rvalid, d_rdata, d_err,
           mem_en, mem_we, mem_be, mem_addr, mem_wdata, i_stall_cnt, d_stall_cnt
  );

endinterface

// File: rtl/gmsk_rr_arb2.sv
// Two-way round-robin arbiter: bit 0 is the instruction port, bit 1 the data port.
module gmsk_rr_arb2
  import gmsk_mem_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       adv,
  output logic [1:0] sel,
  output rr_e        rr_ptr
);

  rr_e rr_ptr_r;

  // Pointer only matters when both ports compete; a lone request passes straight through.
  always_comb begin
    sel = 2'b00;
    case (req)
      2'b11: begin
        if (rr_ptr_r == DATA_FIRST) begin
          sel = 2'b10;
        end else begin
          sel = 2'b01;
        end
      end
      2'b10:   sel = 2'b10;
      2'b01:   sel = 2'b01;
      default: sel = 2'b00;
    endcase
  end

  // Pointer register, flipped only after a contended grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_r <= DATA_FIRST;
    end else if (adv) begin
      rr_ptr_r <= rr_other(rr_ptr_r);
    end
  end

  assign rr_ptr = rr_ptr_r;

endmodule

// File: rtl/gmsk_mem_arbiter.sv
// Shares one single-port SRAM between the core instruction and data ports and
// routes fixed-latency responses back to their owner in grant order.
module gmsk_mem_arbiter
  import gmsk_mem_pkg::*;
#(
  parameter int MEM_WORDS = 4096,
  parameter int RD_LAT    = 1,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  gmsk_mem_arbiter_if.slave bus
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef struct packed {
    resp_tag_t tag;
    logic      wr;
  } stage_t;

  logic [1:0]          req_s;
  logic [1:0]          sel_s;
  logic                i_oor_s;
  logic                d_oor_s;
  logic                sel_oor_s;
  logic                gnt_s;
  logic                i_gnt_s;
  logic                d_gnt_s;
  logic                adv_s;
  rr_e                 rr_ptr_s;
  stage_t              push_s;
  stage_t              head_s;
  stage_t [RD_LAT-1:0] pipe_r;
  stage_t [RD_LAT:0]   pipe_next_s;
  logic [CNT_W-1:0]    i_stall_r;
  logic [CNT_W-1:0]    d_stall_r;
  logic                unused_s;

  assign unused_s = ^{bus.i_addr[1:0], bus.d_addr[1:0], rr_ptr_s};
  assign i_oor_s  = |bus.i_addr[31:AW+2];
  assign d_oor_s  = |bus.d_addr[31:AW+2];
  assign req_s    = {bus.d_req & ~rst, bus.i_req & ~rst};

  gmsk_rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    (req_s),
    .adv    (adv_s),
    .sel    (sel_s),
    .rr_ptr (rr_ptr_s)
  );

  // Out-of-range picks never touch the SRAM, so they are granted without mem_ready.
  always_comb begin
    sel_oor_s = 1'b0;
    if (sel_s[1]) begin
      sel_oor_s = d_oor_s;
    end else if (sel_s[0]) begin
      sel_oor_s = i_oor_s;
    end else begin
      sel_oor_s = 1'b0;
    end
    gnt_s   = (sel_s != 2'b00) && (sel_oor_s || bus.mem_ready);
    d_gnt_s = gnt_s & sel_s[1];
    i_gnt_s = gnt_s & sel_s[0];
    adv_s   = gnt_s && (req_s == 2'b11);
  end

  // SRAM strobe and operands come from whichever port won this cycle.
  always_comb begin
    bus.mem_en = gnt_s & ~sel_oor_s;
    if (sel_s[1]) begin
      bus.mem_we    = bus.d_we & bus.mem_en;
      bus.mem_be    = bus.d_be;
      bus.mem_addr  = bus.d_addr[AW+1:2];
      bus.mem_wdata = bus.d_wdata;
    end else begin
      bus.mem_we    = 1'b0;
      bus.mem_be    = BE_FULL;
      bus.mem_addr  = bus.i_addr[AW+1:2];
      bus.mem_wdata = 32'h0000_0000;
    end
  end

  // Tag for this cycle's grant; idle cycles push OWN_NONE to keep the fixed latency.
  always_comb begin
    push_s = '0;
    if (d_gnt_s) begin
      push_s.tag.owner = OWN_DATA;
    end else if (i_gnt_s) begin
      push_s.tag.owner = OWN_INSTR;
    end else begin
      push_s.tag.owner = OWN_NONE;
    end
    push_s.tag.err = gnt_s & sel_oor_s;
    push_s.wr      = d_gnt_s & bus.d_we;
  end

  assign pipe_next_s = {pipe_r, push_s};
  assign head_s      = pipe_r[RD_LAT-1];

  // Response tag shift register, RD_LAT stages deep.
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_r <= '0;
    end else begin
      pipe_r <= pipe_next_s[RD_LAT-1:0];
    end
  end

  // Route the head tag; errored and write responses carry zero data.
  always_comb begin
    bus.i_rvalid = 1'b0;
    bus.i_rdata  = 32'h0000_0000;
    bus.i_err    = 1'b0;
    bus.d_rvalid = 1'b0;
    bus.d_rdata  = 32'h0000_0000;
    bus.d_err    = 1'b0;
    if (!rst) begin
      case (head_s.tag.owner)
        OWN_INSTR: begin
          bus.i_rvalid = 1'b1;
          bus.i_err    = head_s.tag.err;
          bus.i_rdata  = head_s.tag.err ? 32'h0000_0000 : bus.mem_rdata;
        end
        OWN_DATA: begin
          bus.d_rvalid = 1'b1;
          bus.d_err    = head_s.tag.err;
          bus.d_rdata  = (head_s.tag.err || head_s.wr) ? 32'h0000_0000 : bus.mem_rdata;
        end
        default: begin
          bus.i_rvalid = 1'b0;
          bus.d_rvalid = 1'b0;
        end
      endcase
    end else begin
      bus.i_rvalid = 1'b0;
      bus.d_rvalid = 1'b0;
    end
  end

  // Saturating stall counters for bring-up visibility.
  always_ff @(posedge clk) begin
    if (rst) begin
      i_stall_r <= {CNT_W{1'b0}};
      d_stall_r <= {CNT_W{1'b0}};
    end else begin
      if (bus.i_req && !i_gnt_s && (i_stall_r != CNT_MAX)) begin
        i_stall_r <= i_stall_r + CNT_ONE;
      end
      if (bus.d_req && !d_gnt_s && (d_stall_r != CNT_MAX)) begin
        d_stall_r <= d_stall_r + CNT_ONE;
      end
    end
  end

  assign bus.i_gnt       = i_gnt_s;
  assign bus.d_gnt       = d_gnt_s;
  assign bus.i_stall_cnt = i_stall_r;
  assign bus.d_stall_cnt = d_stall_r;

endmodule

// File: tb/tb_gmsk_mem_arbiter.sv
// Directed bench: table of single-cycle vectors on an RD_LAT=1 instance, plus
// hand sequences for back-pressure, saturation and reset on an RD_LAT=2 instance.
module tb_gmsk_mem_arbiter;

  typedef struct {
    logic        ir;  logic [31:0] ia;
    logic        dr;  logic        dwe; logic [3:0] dbe; logic [31:0] da; logic [31:0] dwd;
    logic        rdy;
    logic        eig; logic        edg; logic       een; logic        ewe; logic [3:0] ebe;
    logic [11:0] ema;
    logic        eiv; logic [31:0] eir; logic       eie;
    logic        edv; logic [31:0] edr; logic       ede;
  } vec_t;

  localparam int NV = 17;

  logic        clk = 1'b0;
  logic        rst_a;
  logic        rst_b;
  logic        mem_load;
  logic [31:0] mem_a [4096];
  logic [31:0] mem_b [4096];
  logic [31:0] rd_a;
  logic [31:0] rd_b1;
  logic [31:0] rd_b2;
  int          n_checks;
  int          n_err;
  vec_t        vec [NV];

  always #5 clk = ~clk;

  gmsk_mem_arbiter_if #(.MEM_WORDS(4096), .CNT_W(16)) bus_a ();
  gmsk_mem_arbiter_if #(.MEM_WORDS(4096), .CNT_W(2))  bus_b ();

  gmsk_mem_arbiter #(.MEM_WORDS(4096), .RD_LAT(1), .CNT_W(16)) dut_a (.clk(clk), .rst(rst_a), .bus(bus_a));
  gmsk_mem_arbiter #(.MEM_WORDS(4096), .RD_LAT(2), .CNT_W(2))  dut_b (.clk(clk), .rst(rst_b), .bus(bus_b));

  function automatic logic [31:0] init_word(input int k);
    return (k == 8) ? 32'h1122_3344 : 32'h1000_0000 + 32'(k);
  endfunction

  // SRAM model, one-cycle read latency
  always @(posedge clk) begin
    if (mem_load) begin
      for (int k = 0; k < 4096; k++) mem_a[k] <= init_word(k);
      rd_a <= 32'h0;
    end else if (bus_a.mem_en && bus_a.mem_ready) begin
      if (bus_a.mem_we)
        for (int b = 0; b < 4; b++)
          if (bus_a.mem_be[b]) mem_a[bus_a.mem_addr][8*b +: 8] <= bus_a.mem_wdata[8*b +: 8];
      rd_a <= mem_a[bus_a.mem_addr];
    end
  end
  assign bus_a.mem_rdata = rd_a;

  // SRAM model, two-cycle read latency
  always @(posedge clk) begin
    if (mem_load) begin
      for (int k = 0; k < 4096; k++) mem_b[k] <= init_word(k);
      rd_b1 <= 32'h0;
      rd_b2 <= 32'h0;
    end else begin
      if (bus_b.mem_en && bus_b.mem_ready) begin
        if (bus_b.mem_we)
          for (int b = 0; b < 4; b++)
            if (bus_b.mem_be[b]) mem_b[bus_b.mem_addr][8*b +: 8] <= bus_b.mem_wdata[8*b +: 8];
        rd_b1 <= mem_b[bus_b.mem_addr];
      end
      rd_b2 <= rd_b1;
    end
  end
  assign bus_b.mem_rdata = rd_b2;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_a();
    bus_a.i_req = 1'b0; bus_a.i_addr = 32'h0; bus_a.d_req = 1'b0; bus_a.d_we = 1'b0;
    bus_a.d_be = 4'hF; bus_a.d_addr = 32'h0; bus_a.d_wdata = 32'h0; bus_a.mem_ready = 1'b1;
  endtask

  task automatic idle_b();
    bus_b.i_req = 1'b0; bus_b.i_addr = 32'h0; bus_b.d_req = 1'b0; bus_b.d_we = 1'b0;
    bus_b.d_be = 4'hF; bus_b.d_addr = 32'h0; bus_b.d_wdata = 32'h0; bus_b.mem_ready = 1'b1;
  endtask

  task automatic apply_a(input vec_t v);
    bus_a.i_req = v.ir; bus_a.i_addr = v.ia; bus_a.d_req = v.dr; bus_a.d_we = v.dwe;
    bus_a.d_be = v.dbe; bus_a.d_addr = v.da; bus_a.d_wdata = v.dwd; bus_a.mem_ready = v.rdy;
  endtask

  initial begin
    n_checks = 0;
    n_err    = 0;
    // inputs:   ir  ia            dr  dwe dbe    da             dwd            rdy
    // expected: ig  dg  en  we  be     maddr   iv  irdata        ie   dv  drdata        de
    vec[0]  = '{1'b0, 32'h0,    1'b0, 1'b0, 4'hF, 32'h0, 32'h0, 1'b1,
                1'b0, 1'b0, 1'b0, 1'b0, 4'hF, 12'd0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0};
    vec[1]  = '{1'b1, 32'h10,   1'b0, 1'b0, 4'hF, 32'h0, 32'h0, 1'b1,
                1'b1, 1'b0, 1'b1, 1'b0, 4'hF, 12'd4, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0};
    vec[2]  = '{1'b0, 32'h0,    1'b0, 1'b0, 4'hF, 32'h0, 32'h0, 1'b1,
                1'b0, 1'b0, 1'b0, 1'b0, 4'hF, 12'd0, 1'b1, 32'h1000_0004, 1'b0, 1'b0, 32'h0, 1'b0};
    vec[3]  = '{1'b1, 32'h4,    1'b1, 1'b0, 4'hF, 32'h8, 32'h0, 1'b1,
                1'b0, 1'b1, 1'b1, 1'b0, 4'hF, 12'd2, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0};
    vec[4]  = '{1'b1, 32'h4,    1'b1, 1'b0, 4'hF, 32'h8, 32'h0, 1'b1,
                1'b1, 1'b0, 1'b1, 1'b0, 4'hF, 12'd1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h1000_0002, 1'b0};
    vec[5]  = '{1'b1, 32'h4,    1'b1, 1'b0, 4'hF, 32'h8, 32'h0, 1'b1,
                1'b0, 1'b1, 1'b1, 1'b0, 4'hF, 12'd2, 1'b1, 32'h1000_0001, 1'b0, 1'b0, 32'h0, 1'b0};
    vec[6]  = '{1'b1, 32'h4,    1'b1, 1'b0, 4'hF, 32'h8, 32'h0, 1'b1,
                1'b1, 1'b0, 1'b1, 1'b0, 4'hF, 12'd1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h1000_0002, 1'b0};
    vec[7]  = '{1'b0, 32'h0,    1'b0, 1'b0, 4'hF, 32'h0, 32'h0, 1'b1,
                1'b0, 1'b0, 1'b0, 1'b0, 4'hF, 12'd0, 1'b1, 32'h1000_0001, 1'b0, 1'b0, 32'h0, 1'b0};
    vec[8]  = '{1'b0, 32'h0,    1'b1, 1'b1, 4'b0011, 32'h20, 32'hAABB_CCDD, 1'b1,
                1'b0, 1'b1, 1'b1, 1'b1, 4'b0011, 12'd8, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0};
    vec[9]  = '{1'b0, 32'h0,    1'b1, 1'b0, 4'hF, 32'h20, 32'h0, 1'b1,
                1'b0, 1'b1, 1'b1, 1'b0, 4'hF, 12'd8, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0};
    vec[10] = '{1'b0, 32'h0,    1'b0, 1'b0, 4'hF, 32'h0, 32'h0, 1'b1,
                1'b0, 1'b0, 1'b0, 1'b0, 4'hF, 12'd0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h1122_CCDD, 1'b0};
    vec[11] = '{1'b1, 32'h4000, 1'b0, 1'b0, 4'hF, 32'h0, 32'h0, 1'b0,
                1'b1, 1'b0, 1'b0, 1'b0, 4'hF, 12'd0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0};
    vec[12] = '{1'b0, 32'h0,    1'b0, 1'b0, 4'hF, 32'h0, 32'h0, 1'b0,
                1'b0, 1'b0, 1'b0, 1'b0, 4'hF, 12'd0, 1'b1, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0};
    vec[13] = '{1'b0, 32'h0,    1'b1, 1'b0, 4'hF, 32'hFFFF_FFFC, 32'h0, 1'b1,
                1'b0, 1'b1, 1'b0, 1'b0, 4'hF, 12'd0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0};
    vec[14] = '{1'b0, 32'h0,    1'b0, 1'b0, 4'hF, 32'h0, 32'h0, 1'b1,
                1'b0, 1'b0, 1'b0, 1'b0, 4'hF, 12'd0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b1};
    vec[15] = '{1'b1, 32'h13,   1'b0, 1'b0, 4'hF, 32'h0, 32'h0, 1'b1,
                1'b1, 1'b0, 1'b1, 1'b0, 4'hF, 12'd4, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0};
    vec[16] = '{1'b0, 32'h0,    1'b0, 1'b0, 4'hF, 32'h0, 32'h0, 1'b1,
                1'b0, 1'b0, 1'b0, 1'b0, 4'hF, 12'd0, 1'b1, 32'h1000_0004, 1'b0, 1'b0, 32'h0, 1'b0};

    rst_a = 1'b1; rst_b = 1'b1; mem_load = 1'b1;
    idle_a(); idle_b();
    tick();
    mem_load = 1'b0;

    // requests during reset must not be granted
    bus_a.i_req = 1'b1; bus_a.i_addr = 32'h10; bus_a.d_req = 1'b1; bus_a.d_addr = 32'h8;
    #1;
    chk("rst i_gnt", 32'(bus_a.i_gnt), 32'h0);
    chk("rst d_gnt", 32'(bus_a.d_gnt), 32'h0);
    chk("rst mem_en", 32'(bus_a.mem_en), 32'h0);
    chk("rst i_rvalid", 32'(bus_a.i_rvalid), 32'h0);
    chk("rst d_rvalid", 32'(bus_a.d_rvalid), 32'h0);
    tick();
    chk("rst i_stall", 32'(bus_a.i_stall_cnt), 32'h0);
    chk("rst d_stall", 32'(bus_a.d_stall_cnt), 32'h0);
    idle_a();
    rst_a = 1'b0; rst_b = 1'b0;

    for (int v = 0; v < NV; v++) begin
      apply_a(vec[v]);
      #1;
      chk($sformatf("v%0d i_gnt", v),    32'(bus_a.i_gnt),    32'(vec[v].eig));
      chk($sformatf("v%0d d_gnt", v),    32'(bus_a.d_gnt),    32'(vec[v].edg));
      chk($sformatf("v%0d mem_en", v),   32'(bus_a.mem_en),   32'(vec[v].een));
      if (vec[v].een) begin
        chk($sformatf("v%0d mem_addr", v), 32'(bus_a.mem_addr), 32'(vec[v].ema));
        chk($sformatf("v%0d mem_we", v),   32'(bus_a.mem_we),   32'(vec[v].ewe));
        chk($sformatf("v%0d mem_be", v),   32'(bus_a.mem_be),   32'(vec[v].ebe));
      end
      chk($sformatf("v%0d i_rvalid", v), 32'(bus_a.i_rvalid), 32'(vec[v].eiv));
      chk($sformatf("v%0d i_rdata", v),  bus_a.i_rdata,       vec[v].eir);
      chk($sformatf("v%0d d_rvalid", v), 32'(bus_a.d_rvalid), 32'(vec[v].edv));
      chk($sformatf("v%0d d_rdata", v),  bus_a.d_rdata,       vec[v].edr);
      if (vec[v].eiv) chk($sformatf("v%0d i_err", v), 32'(bus_a.i_err), 32'(vec[v].eie));
      if (vec[v].edv) chk($sformatf("v%0d d_err", v), 32'(bus_a.d_err), 32'(vec[v].ede));
      tick();
    end
    idle_a();
    chk("table i_stall", 32'(bus_a.i_stall_cnt), 32'd2);
    chk("table d_stall", 32'(bus_a.d_stall_cnt), 32'd2);

    // back-pressure: three stalled cycles, granted on the fourth
    rst_a = 1'b1; tick(); rst_a = 1'b0;
    for (int c = 0; c < 4; c++) begin
      bus_a.d_req = 1'b1; bus_a.d_addr = 32'h8; bus_a.mem_ready = (c == 3);
      #1;
      chk($sformatf("bp c%0d d_gnt", c), 32'(bus_a.d_gnt), (c == 3) ? 32'h1 : 32'h0);
      tick();
    end
    idle_a();
    #1;
    chk("bp d_stall", 32'(bus_a.d_stall_cnt), 32'd3);
    chk("bp i_stall", 32'(bus_a.i_stall_cnt), 32'd0);
    chk("bp d_rvalid", 32'(bus_a.d_rvalid), 32'h1);
    chk("bp d_rdata", bus_a.d_rdata, 32'h1000_0002);

    // two-bit counter saturates; two-cycle response latency
    for (int c = 0; c < 6; c++) begin
      bus_b.d_req = 1'b1; bus_b.d_addr = 32'h8; bus_b.mem_ready = (c == 5);
      #1;
      chk($sformatf("sat c%0d d_gnt", c), 32'(bus_b.d_gnt), (c == 5) ? 32'h1 : 32'h0);
      tick();
    end
    idle_b();
    #1;
    chk("sat d_stall", 32'(bus_b.d_stall_cnt), 32'd3);
    chk("lat2 early d_rvalid", 32'(bus_b.d_rvalid), 32'h0);
    tick();
    chk("lat2 d_rvalid", 32'(bus_b.d_rvalid), 32'h1);
    chk("lat2 d_rdata", bus_b.d_rdata, 32'h1000_0002);
    tick();

    // contended data read, then reset while it is in flight
    bus_b.i_req = 1'b1; bus_b.i_addr = 32'h4; bus_b.d_req = 1'b1; bus_b.d_addr = 32'h8;
    #1;
    chk("mid d_gnt", 32'(bus_b.d_gnt), 32'h1);
    tick();
    rst_b = 1'b1; bus_b.i_req = 1'b0;
    #1;
    chk("mid rst d_gnt", 32'(bus_b.d_gnt), 32'h0);
    chk("mid rst mem_en", 32'(bus_b.mem_en), 32'h0);
    chk("mid rst d_rvalid", 32'(bus_b.d_rvalid), 32'h0);
    tick();
    rst_b = 1'b0;
    idle_b();
    for (int c = 0; c < 4; c++) begin
      #1;
      chk($sformatf("mid c%0d d_rvalid", c), 32'(bus_b.d_rvalid), 32'h0);
      tick();
    end
    chk("mid i_stall", 32'(bus_b.i_stall_cnt), 32'd0);
    chk("mid d_stall", 32'(bus_b.d_stall_cnt), 32'd0);
    bus_b.i_req = 1'b1; bus_b.i_addr = 32'h4; bus_b.d_req = 1'b1; bus_b.d_addr = 32'h8;
    #1;
    chk("post rst d_gnt", 32'(bus_b.d_gnt), 32'h1);
    chk("post rst i_gnt", 32'(bus_b.i_gnt), 32'h0);
    tick();
    idle_b();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/gmsk_mem_arbiter.md
Name: gmsk_mem_arbiter

Overview:
Shares one single-port synchronous SRAM between the core's instruction and data request/grant/rvalid interfaces. Replaces the separate instruction ROM and tied-off data port in the SoC wrapper, giving one unified memory.
- Two-way round-robin arbitration with memory back-pressure.
- Fixed-latency, in-order response routing.
- Out-of-range decode error.
- Per-requester stall counters for bring-up.

Parameters:
MEM_WORDS, 4096, memory depth in 32-bit words; power of two; byte range is 0 to MEM_WORDS*4-1
RD_LAT, 1, memory read latency in cycles from accepted mem_en to mem_rdata valid; legal values 1 or 2
CNT_W, 16, width of the saturating stall counters

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
i_req  in  1  instruction request
i_addr  in  32  instruction byte address
i_gnt  out  1  instruction grant (combinational)
i_rvalid  out  1  instruction response valid
i_rdata  out  32  instruction read data
i_err  out  1  instruction decode error, qualified by i_rvalid
d_req  in  1  data request
d_we  in  1  data write enable
d_be  in  4  data byte enables
d_addr  in  32  data byte address
d_wdata  in  32  data write data
d_gnt  out  1  data grant (combinational)
d_rvalid  out  1  data response valid, for reads and writes
d_rdata  out  32  data read data
d_err  out  1  data decode error, qualified by d_rvalid
mem_en  out  1  memory access strobe
mem_we  out  1  memory write
mem_be  out  4  memory byte enables
mem_addr  out  $clog2(MEM_WORDS)  memory word address, equal to byte address[AW+1:2]
mem_wdata  out  32  memory write data
mem_ready  in  1  memory accepts an access this cycle
mem_rdata  in  32  memory read data, RD_LAT cycles after acceptance
i_stall_cnt  out  CNT_W  cycles in which i_req=1 and i_gnt=0; saturating
d_stall_cnt  out  CNT_W  cycles in which d_req=1 and d_gnt=0; saturating

Behaviour:
- Reset (rst=1 at a clk edge):
  - Response tag pipeline cleared, so all in-flight responses are dropped.
  - rr_ptr set to DATA_FIRST; both stall counters set to 0.
  - While rst=1: i_gnt=d_gnt=0, mem_en=0, i_rvalid=d_rvalid=0, rdata=0.
- Selection each cycle: when exactly one requester asserts req, it is selected. When both assert, the one indicated by rr_ptr is selected.
- rr_ptr update: on every grant given to a requester while both requested, rr_ptr flips to favour the other requester. Otherwise rr_ptr holds.
- Grant:
  - In-range selected request: gnt=1 only when mem_ready=1. The accepted cycle drives mem_en=1, with mem_we/be/wdata from the data port. Instruction accesses use mem_we=0 and be=4'hF.
  - Out-of-range selected request (addr >= MEM_WORDS*4): gnt=1 regardless of mem_ready, mem_en=0, and a tag {owner, err=1} is pushed.
- Unselected requester: gnt=0 that cycle.
- Request rule: requesters hold req, addr, we, be and wdata stable until gnt.
- Response pipeline: a shift register of RD_LAT stages, each holding an owner tag (NONE/INSTR/DATA) plus err.
  - Each grant pushes one tag; all responses return exactly RD_LAT cycles after gnt, in grant order.
  - One grant per cycle maximum, so there is never more than one response per cycle.
- Response routing at the pipeline output:
  - Owner INSTR: i_rvalid=1, i_rdata = err ? 0 : mem_rdata, i_err = err.
  - Owner DATA: the same on the d_ side. Writes also produce d_rvalid, with d_rdata=0.
  - Owner NONE: both rvalid=0 and both rdata=0.
- mem_ready=0 with an in-range request: no grant, stall counters increment, and rr_ptr is unchanged.
- Counters saturate at all-ones and do not wrap.
- Address low bits [1:0] are ignored; no misalignment fault is raised.
- A back-to-back grant every cycle gives full throughput: one access per cycle.

Decomposition:
- Package gmsk_mem_pkg:
  - owner_e enum {OWN_NONE, OWN_INSTR, OWN_DATA}.
  - rr_e enum {DATA_FIRST, INSTR_FIRST}.
  - resp_tag_t struct {owner_e owner; logic err}.
  - Constant BE_FULL = 4'hF.
- Sub-module gmsk_rr_arb2: a two-way round-robin arbiter. It takes req[1:0] and an advance enable, and outputs a one-hot select plus the rr_ptr register.

Test Plan:
- Single instruction fetch: after reset, i_req=1, i_addr=0x0000_0010, mem_ready=1 → i_gnt=1 in the same cycle and mem_addr=4. One cycle later i_rvalid=1 and i_rdata equals memory word 4.
- Contention: i_req=d_req=1 held for 4 cycles, mem_ready=1 → grants are D, I, D, I. rvalid follows the same order, each one cycle after its grant.
- Data write then read back: write d_addr=0x20, be=4'b0011, wdata=0xAABB_CCDD over old word 0x1122_3344 → d_rvalid with d_rdata=0. A following read of 0x20 returns 0x1122_CCDD.
- Back-pressure: d_req=1 with mem_ready=0 for 3 cycles, then 1 → d_gnt is asserted only in cycle 4 and d_stall_cnt=3. Repeat with CNT_W=2 → the counter saturates at 3.
- Decode error: i_addr=MEM_WORDS*4 (0x4000) with mem_ready=0 → i_gnt=1, mem_en=0. Next cycle i_rvalid=1, i_err=1, i_rdata=0.
- Reset mid-operation (RD_LAT=2): grant a d read, then assert rst the next cycle → no d_rvalid ever appears and the counters read 0. Next both-request grant goes to D.
